// File: rtl/imem_arb_pkg.sv
// -----------------------------------------------------------------------------
// imem_arb_pkg
// Purpose : Shared types and default constants for the instruction-memory
//           arbiter (imem_arbiter) and its round-robin picker (rr_pick).
// Contents: arb_state_t  - arbiter FSM state (IDLE, BUSY)
//           *_DEF        - default values for the arbiter parameters
// -----------------------------------------------------------------------------
package imem_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    localparam int ISIZE_DEF     = 32;
    localparam int N_PORTS_DEF   = 2;
    localparam int BURST_MAX_DEF = 4;

endpackage

// File: rtl/imem_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Purpose : Rotating-priority search. Returns the first set bit of i_req found
//           by scanning upward from index i_start with wrap-around.
// Ports   : i_req    [N-1:0]  request vector
//           i_start  [IW-1:0] index with highest priority (must be < N)
//           o_winner [N-1:0]  one-hot winner (all zeros when no request)
//           o_valid           at least one request present
// -----------------------------------------------------------------------------
module rr_pick #(
    parameter int N  = 2,
    parameter int IW = 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_start,
    output logic [N-1:0]  o_winner,
    output logic          o_valid
);

    logic [2*N-1:0] w_dbl;
    logic [2*N-1:0] w_back;
    logic [N-1:0]   w_rot;
    logic [N-1:0]   w_lsb;

    // Rotate so i_start lands on bit 0, isolate the lowest set bit, then
    // rotate back. The doubled vector makes the shifts behave as rotates.
    assign w_dbl    = {i_req, i_req} >> i_start;
    assign w_rot    = w_dbl[N-1:0];
    assign w_lsb    = w_rot & (~w_rot + 1'b1);
    assign w_back   = {w_lsb, w_lsb} << i_start;
    assign o_winner = w_back[2*N-1:N];
    assign o_valid  = |i_req;

endmodule

// File: rtl/imem_arbiter.sv
// -----------------------------------------------------------------------------
// imem_arbiter
// Purpose : Shares one combinational instruction-memory read port among
//           N_PORTS fetch requesters. Round-robin between owners, with an
//           owner allowed up to BURST_MAX back-to-back fetches.
// Ports   : clock, nReset      rising-edge clock, async active-low reset
//           req   [N_PORTS]    fetch request per port (held until gnt)
//           addr  [N_PORTS][Isize] fetch byte address per port
//           gnt   [N_PORTS]    one-hot grant, combinational
//           rvalid[N_PORTS]    one-hot response valid, one cycle after gnt
//           rdata [Isize]      registered instruction, shared by all ports
//           mem_addr [Isize]   address to instruction memory (0 when idle)
//           mem_instr[Isize]   combinational read data from memory
// Option  : IMEM_ARB_STATS_EN adds grant_cnt[N_PORTS][16], saturating
//           per-port grant counters.
// -----------------------------------------------------------------------------
module imem_arbiter
    import imem_arb_pkg::*;
#(
    parameter int Isize     = ISIZE_DEF,
    parameter int N_PORTS   = N_PORTS_DEF,
    parameter int BURST_MAX = BURST_MAX_DEF
) (
    input  logic                            clock,
    input  logic                            nReset,
    input  logic [N_PORTS-1:0]              req,
    input  logic [N_PORTS-1:0][Isize-1:0]   addr,
    output logic [N_PORTS-1:0]              gnt,
    output logic [N_PORTS-1:0]              rvalid,
    output logic [Isize-1:0]                rdata,
    output logic [Isize-1:0]                mem_addr,
    input  logic [Isize-1:0]                mem_instr
`ifdef IMEM_ARB_STATS_EN
    ,
    output logic [N_PORTS-1:0][15:0]        grant_cnt
`endif
);

    localparam int IW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

    arb_state_t         r_state;
    arb_state_t         w_state_nxt;
    logic [IW-1:0]      r_owner;
    logic [IW-1:0]      r_rr_ptr;
    logic [3:0]         r_bcnt;
    logic               r_armed;

    logic [IW-1:0]      w_owner_inc;
    logic [IW-1:0]      w_start;
    logic [IW-1:0]      w_gnt_idx;
    logic [N_PORTS-1:0] w_owner_oh;
    logic [N_PORTS-1:0] w_pick;
    logic [N_PORTS-1:0] w_gnt;
    logic               w_pick_vld;
    logic               w_keep;

    // r_armed is cleared by reset and set on the first edge with nReset high,
    // so no grant can appear before that edge even if reset releases mid-cycle.
    assign w_owner_inc = (r_owner == IW'(N_PORTS - 1)) ? '0 : r_owner + 1'b1;
    assign w_keep      = r_armed && (r_state == BUSY) && req[r_owner] &&
                         (r_bcnt < 4'(BURST_MAX));
    // On release the search starts just past the owner, which leaves the
    // previous owner last in priority order.
    assign w_start     = (r_state == BUSY) ? w_owner_inc : r_rr_ptr;
    assign w_owner_oh  = {{(N_PORTS-1){1'b0}}, 1'b1} << r_owner;

    rr_pick #(
        .N  (N_PORTS),
        .IW (IW)
    ) u_rr_pick (
        .i_req    (req),
        .i_start  (w_start),
        .o_winner (w_pick),
        .o_valid  (w_pick_vld)
    );

    // FSM: state register
    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) r_state <= IDLE;
        else         r_state <= w_state_nxt;
    end

    // FSM: next state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: if (r_armed && w_pick_vld)  w_state_nxt = BUSY;
            BUSY: if (!w_keep && !w_pick_vld) w_state_nxt = IDLE;
            default:                          w_state_nxt = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        w_gnt = '0;
        if (r_armed) begin
            if (w_keep)          w_gnt = w_owner_oh;
            else if (w_pick_vld) w_gnt = w_pick;
        end
    end

    always_comb begin
        w_gnt_idx = '0;
        for (int i = 0; i < N_PORTS; i++)
            if (w_gnt[i]) w_gnt_idx = IW'(i);
    end

    assign gnt      = w_gnt;
    assign mem_addr = (|w_gnt) ? addr[w_gnt_idx] : '0;

    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            r_armed  <= 1'b0;
            r_owner  <= '0;
            r_rr_ptr <= '0;
            r_bcnt   <= '0;
            rvalid   <= '0;
            rdata    <= '0;
        end else begin
            r_armed <= 1'b1;
            rvalid  <= w_gnt;
            if (|w_gnt) begin
                rdata <= mem_instr;
                if (w_keep) begin
                    r_bcnt <= r_bcnt + 4'd1;
                end else begin
                    r_owner <= w_gnt_idx;
                    r_bcnt  <= 4'd1;
                end
            end
            if ((r_state == BUSY) && !w_keep)
                r_rr_ptr <= w_owner_inc;
        end
    end

`ifdef IMEM_ARB_STATS_EN
    for (genvar g = 0; g < N_PORTS; g++) begin : g_stats
        always_ff @(posedge clock or negedge nReset) begin
            if (!nReset)
                grant_cnt[g] <= '0;
            else if (w_gnt[g] && (grant_cnt[g] != 16'hFFFF))
                grant_cnt[g] <= grant_cnt[g] + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_imem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_imem_arbiter
// Directed bench for imem_arbiter (N_PORTS=2, BURST_MAX=4, Isize=32).
// The instruction memory is a tiny combinational model: word 2 holds
// 32'h00500093, every other address returns {16'hA5A5, addr[15:0]}.
// Define IMEM_ARB_STATS_EN to also exercise the grant counters.
// -----------------------------------------------------------------------------
module tb_imem_arbiter;

    localparam logic [31:0] A0   = 32'h0000_0008;
    localparam logic [31:0] A1   = 32'h0000_0040;
    localparam logic [31:0] EXP0 = 32'h0050_0093;
    localparam logic [31:0] EXP1 = 32'hA5A5_0040;

    logic              clock;
    logic              nReset;
    logic [1:0]        req;
    logic [1:0][31:0]  addr;
    logic [1:0]        gnt;
    logic [1:0]        rvalid;
    logic [31:0]       rdata;
    logic [31:0]       mem_addr;
    logic [31:0]       mem_instr;
`ifdef IMEM_ARB_STATS_EN
    logic [1:0][15:0]  grant_cnt;
`endif

    int          n_chk;
    int          n_err;
    logic [31:0] exp_rd;

    imem_arbiter #(
        .Isize     (32),
        .N_PORTS   (2),
        .BURST_MAX (4)
    ) dut (
        .clock     (clock),
        .nReset    (nReset),
        .req       (req),
        .addr      (addr),
        .gnt       (gnt),
        .rvalid    (rvalid),
        .rdata     (rdata),
        .mem_addr  (mem_addr),
        .mem_instr (mem_instr)
`ifdef IMEM_ARB_STATS_EN
        ,
        .grant_cnt (grant_cnt)
`endif
    );

    assign mem_instr = (mem_addr[31:2] == 30'd2) ? 32'h0050_0093
                                                 : {16'hA5A5, mem_addr[15:0]};

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at posedge+1: drive req, check comb outputs mid-cycle, then
    // check the registered response just after the next edge.
    task automatic step(input string tag, input logic [1:0] r, input logic [1:0] eg);
        req = r;
        #4;
        chk({tag, " gnt"}, 32'(gnt), 32'(eg));
        chk({tag, " mem_addr"}, mem_addr, (eg == 2'b01) ? A0 : (eg == 2'b10) ? A1 : 32'h0);
        @(posedge clock);
        #1;
        if (eg == 2'b01) exp_rd = EXP0;
        if (eg == 2'b10) exp_rd = EXP1;
        chk({tag, " rvalid"}, 32'(rvalid), 32'(eg));
        chk({tag, " rdata"}, rdata, exp_rd);
    endtask

    task automatic zero_chk(input string tag);
        chk({tag, " gnt"}, 32'(gnt), 32'h0);
        chk({tag, " rvalid"}, 32'(rvalid), 32'h0);
        chk({tag, " rdata"}, rdata, 32'h0);
        chk({tag, " mem_addr"}, mem_addr, 32'h0);
    endtask

    // Assert reset with both ports requesting, release mid-cycle, and leave
    // the bench at posedge+1 of the first edge with nReset high.
    task automatic do_reset(input string tag);
        req    = 2'b11;
        nReset = 1'b0;
        #1;
        zero_chk(tag);
        exp_rd = 32'h0;
        @(posedge clock);
        #3;
        nReset = 1'b1;
        #1;
        chk({tag, " gnt before edge"}, 32'(gnt), 32'h0);
        @(posedge clock);
        #1;
    endtask

    initial begin
        n_chk   = 0;
        n_err   = 0;
        exp_rd  = 32'h0;
        nReset  = 1'b0;
        req     = 2'b00;
        addr[0] = A0;
        addr[1] = A1;
        #12;
        do_reset("rst0");
`ifdef IMEM_ARB_STATS_EN
        chk("stats rst0", 32'(grant_cnt[1]), 32'h0);
`endif

        // single port fetch, 1-cycle latency
        step("single", 2'b01, 2'b01);
        // idle: no grants, rdata held
        for (int i = 0; i < 5; i++) step("idle", 2'b00, 2'b00);

        do_reset("rst1");
        // both requesting: 4-beat bursts alternating
        step("burst0", 2'b11, 2'b01);
        step("burst1", 2'b11, 2'b01);
        step("burst2", 2'b11, 2'b01);
        step("burst3", 2'b11, 2'b01);
        step("burst4", 2'b11, 2'b10);
        step("burst5", 2'b11, 2'b10);
        step("burst6", 2'b11, 2'b10);
        step("burst7", 2'b11, 2'b10);
        step("burst8", 2'b11, 2'b01);
        // port 0 drops after its 2nd grant: handover without idle cycle
        step("drop0", 2'b11, 2'b01);
        step("drop1", 2'b10, 2'b10);
        // reset mid-burst (owner 1, bcnt=2)
        step("mid0", 2'b11, 2'b10);
        req    = 2'b11;
        nReset = 1'b0;
        #1;
        zero_chk("midrst");
        exp_rd = 32'h0;
        @(posedge clock);
        #3;
        nReset = 1'b1;
        @(posedge clock);
        #1;
        step("after", 2'b11, 2'b01);
        // lone requester 1 takes over immediately
        step("lone1", 2'b10, 2'b10);

`ifdef IMEM_ARB_STATS_EN
        do_reset("rst2");
        req = 2'b10;
        repeat (70000) @(posedge clock);
        #1;
        chk("stats sat1", 32'(grant_cnt[1]), 32'h0000_FFFF);
        chk("stats port0", 32'(grant_cnt[0]), 32'h0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
